// File: rtl/vsim_mux_pkg.sv
// Shared types and constants for the simulator port multiplexer.
// Holds FSM state encodings, statistics width and the header layout.
package vsim_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } send_state_t;

  typedef enum logic [1:0] {
    R_HDR  = 2'd0,
    R_BODY = 2'd1,
    R_DROP = 2'd2
  } recv_state_t;

  localparam int STAT_W = 16;

  // Header beat carries the channel id in its low bits; upper bits are zero on send
  localparam int HDR_ID_LSB = 0;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cnt);
    if (cnt == {STAT_W{1'b1}}) begin
      sat_inc = cnt;
    end else begin
      sat_inc = cnt + STAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/vsim_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant.
// Produces both a one-hot and an encoded grant.
module vsim_rr_arbiter #(
  parameter int NUM_CHAN = 4,
  parameter int ID_W     = $clog2(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [ID_W-1:0]     last_grant,
  output logic [NUM_CHAN-1:0] grant_oh,
  output logic [ID_W-1:0]     grant_id
);

  // Scan channels starting just after the previous winner, wrapping around
  always_comb begin
    int   idx;
    logic found;
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_CHAN; off++) begin
      idx = (int'(last_grant) + off) % NUM_CHAN;
      if (!found && req[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_id      = ID_W'(idx);
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/vsim_port_mux.sv
// Multiplexes NUM_CHAN user message streams onto one simulator send/receive pair.
// Optional statistics counters are built only when VSIM_MUX_STATS_EN is defined.
module vsim_port_mux
  import vsim_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_CHAN = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_CHAN-1:0]       up_enq__ENA,
  input  logic [NUM_CHAN*WIDTH-1:0] up_enq_v,
  input  logic [NUM_CHAN-1:0]       up_enq_last,
  output logic [NUM_CHAN-1:0]       up_enq__RDY,
  output logic                      send_enq__ENA,
  output logic [WIDTH-1:0]          send_enq_v,
  output logic                      send_enq_last,
  input  logic                      send_enq__RDY,
  input  logic                      recv_enq__ENA,
  input  logic [WIDTH-1:0]          recv_enq_v,
  input  logic                      recv_enq_last,
  output logic                      recv_enq__RDY,
  output logic [NUM_CHAN-1:0]       down_enq__ENA,
  output logic [WIDTH-1:0]          down_enq_v,
  output logic                      down_enq_last,
  input  logic [NUM_CHAN-1:0]       down_enq__RDY,
  output logic [STAT_W-1:0]         stat_tx_msgs,
  output logic [STAT_W-1:0]         stat_rx_msgs,
  output logic [STAT_W-1:0]         stat_drops
);

  localparam int ID_W = $clog2(NUM_CHAN);

  send_state_t         send_state_r, send_next_s;
  recv_state_t         recv_state_r, recv_next_s;
  logic [ID_W-1:0]     grant_r, last_grant_r, arb_id_s, dest_r, hdr_id_s;
  logic [NUM_CHAN-1:0] grant_oh_r, arb_oh_s;
  logic                tx_last_s, hdr_xfer_s, id_ok_s, drop_s, rx_last_s;

  vsim_rr_arbiter #(.NUM_CHAN(NUM_CHAN), .ID_W(ID_W)) u_arb (
    .req        (up_enq__ENA),
    .last_grant (last_grant_r),
    .grant_oh   (arb_oh_s),
    .grant_id   (arb_id_s)
  );

  assign tx_last_s  = (send_state_r == S_BODY) && up_enq__ENA[grant_r] &&
                      send_enq__RDY && up_enq_last[grant_r];
  assign hdr_id_s   = recv_enq_v[HDR_ID_LSB +: ID_W];
  assign id_ok_s    = int'(hdr_id_s) < NUM_CHAN;
  assign hdr_xfer_s = (recv_state_r == R_HDR) && recv_enq__ENA;
  assign drop_s     = hdr_xfer_s && (recv_enq_last || !id_ok_s);
  assign rx_last_s  = (recv_state_r == R_BODY) && recv_enq__ENA &&
                      down_enq__RDY[dest_r] && recv_enq_last;

  // Send FSM: next state and the send-side handshake outputs
  always_comb begin
    send_next_s   = send_state_r;
    up_enq__RDY   = '0;
    send_enq__ENA = 1'b0;
    send_enq_v    = '0;
    send_enq_last = 1'b0;
    case (send_state_r)
      S_IDLE: begin
        if (|up_enq__ENA) send_next_s = S_HDR;
        else              send_next_s = S_IDLE;
      end
      S_HDR: begin
        send_enq__ENA = 1'b1;
        send_enq_v[HDR_ID_LSB +: ID_W] = grant_r;
        if (send_enq__RDY) send_next_s = S_BODY;
        else               send_next_s = S_HDR;
      end
      S_BODY: begin
        send_enq__ENA = up_enq__ENA[grant_r];
        send_enq_v    = up_enq_v[int'(grant_r)*WIDTH +: WIDTH];
        send_enq_last = up_enq_last[grant_r];
        up_enq__RDY   = grant_oh_r & {NUM_CHAN{send_enq__RDY}};
        if (tx_last_s) send_next_s = S_IDLE;
        else           send_next_s = S_BODY;
      end
      default: send_next_s = S_IDLE;
    endcase
  end

  // Send FSM state, grant lock and round-robin pointer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      send_state_r <= S_IDLE;
      grant_r      <= '0;
      grant_oh_r   <= '0;
      last_grant_r <= ID_W'(NUM_CHAN - 1);
    end else begin
      send_state_r <= send_next_s;
      if ((send_state_r == S_IDLE) && (|up_enq__ENA)) begin
        grant_r    <= arb_id_s;
        grant_oh_r <= arb_oh_s;
      end
      if (tx_last_s) last_grant_r <= grant_r;
    end
  end

  // Receive FSM: header decode, steering and drop handling
  always_comb begin
    recv_next_s   = recv_state_r;
    recv_enq__RDY = 1'b0;
    down_enq__ENA = '0;
    case (recv_state_r)
      R_HDR: begin
        recv_enq__RDY = 1'b1;
        if (drop_s && !recv_enq_last)            recv_next_s = R_DROP;
        else if (hdr_xfer_s && !recv_enq_last)   recv_next_s = R_BODY;
        else                                     recv_next_s = R_HDR;
      end
      R_BODY: begin
        down_enq__ENA[dest_r] = recv_enq__ENA;
        recv_enq__RDY         = down_enq__RDY[dest_r];
        if (rx_last_s) recv_next_s = R_HDR;
        else           recv_next_s = R_BODY;
      end
      R_DROP: begin
        recv_enq__RDY = 1'b1;
        if (recv_enq__ENA && recv_enq_last) recv_next_s = R_HDR;
        else                                recv_next_s = R_DROP;
      end
      default: recv_next_s = R_HDR;
    endcase
  end

  assign down_enq_v    = recv_enq_v;
  assign down_enq_last = recv_enq_last;

  // Receive FSM state and destination channel latch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      recv_state_r <= R_HDR;
      dest_r       <= '0;
    end else begin
      recv_state_r <= recv_next_s;
      if (hdr_xfer_s && !recv_enq_last && id_ok_s) dest_r <= hdr_id_s;
    end
  end

`ifdef VSIM_MUX_STATS_EN
  logic [STAT_W-1:0] tx_cnt_r, rx_cnt_r, drop_cnt_r;

  // Saturating message and drop counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tx_cnt_r   <= '0;
      rx_cnt_r   <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (tx_last_s) tx_cnt_r   <= sat_inc(tx_cnt_r);
      if (rx_last_s) rx_cnt_r   <= sat_inc(rx_cnt_r);
      if (drop_s)    drop_cnt_r <= sat_inc(drop_cnt_r);
    end
  end

  assign stat_tx_msgs = tx_cnt_r;
  assign stat_rx_msgs = rx_cnt_r;
  assign stat_drops   = drop_cnt_r;
`else
  assign stat_tx_msgs = '0;
  assign stat_rx_msgs = '0;
  assign stat_drops   = '0;
`endif

endmodule

// File: tb/tb_vsim_port_mux.sv
// Randomized bench for vsim_port_mux against a message-level reference model.
// Six channels so that header ids 6 and 7 exercise the out-of-range drop path.
module tb_vsim_port_mux;
  import vsim_mux_pkg::*;

  localparam int W    = 32;
  localparam int N    = 6;
  localparam int ID_W = $clog2(N);

  logic           CLK, nRST;
  logic [N-1:0]   up_ena, up_last, up_rdy;
  logic [N*W-1:0] up_v;
  logic           send_ena, send_last, send_rdy;
  logic [W-1:0]   send_v;
  logic           recv_ena, recv_last, recv_rdy;
  logic [W-1:0]   recv_v;
  logic [N-1:0]   down_ena, down_rdy;
  logic [W-1:0]   down_v;
  logic           down_last;
  logic [15:0]    stat_tx, stat_rx, stat_drops;

  vsim_port_mux #(.WIDTH(W), .NUM_CHAN(N)) dut (
    .CLK(CLK), .nRST(nRST),
    .up_enq__ENA(up_ena), .up_enq_v(up_v), .up_enq_last(up_last), .up_enq__RDY(up_rdy),
    .send_enq__ENA(send_ena), .send_enq_v(send_v), .send_enq_last(send_last),
    .send_enq__RDY(send_rdy),
    .recv_enq__ENA(recv_ena), .recv_enq_v(recv_v), .recv_enq_last(recv_last),
    .recv_enq__RDY(recv_rdy),
    .down_enq__ENA(down_ena), .down_enq_v(down_v), .down_enq_last(down_last),
    .down_enq__RDY(down_rdy),
    .stat_tx_msgs(stat_tx), .stat_rx_msgs(stat_rx), .stat_drops(stat_drops)
  );

  typedef struct packed { logic last; logic [W-1:0] data; } beat_t;
  typedef struct packed { logic [7:0] ch; logic last; logic [W-1:0] data; } dn_t;

  beat_t tx_q[N][$];
  beat_t exp_q[N][$];
  beat_t rx_q[$];
  dn_t   dn_exp[$];
  int    hdr_log[$];
  bit    pres[N];
  bit    rx_pres, hdr_checked, idle_prev;
  logic [N-1:0] ena_prev;
  int gap_pct, srdy_pct, rx_gap_pct, drdy_pct, stall_hold, stalls;
  int mon_mode, cur_ch, last_m, rr_base;
  int n_cmp, n_bad, tx_msgs_m, rx_msgs_m, drops_m;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] ena, input int last);
    for (int off = 1; off <= N; off++) begin
      if (ena[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    bit e = (rx_q.size() == 0) && !rx_pres && (dn_exp.size() == 0) && (mon_mode == 0);
    for (int c = 0; c < N; c++) e = e && (tx_q[c].size() == 0) && (exp_q[c].size() == 0) && !pres[c];
    return e;
  endfunction

  task automatic push_tx(input int c, input logic [W-1:0] d, input bit l);
    tx_q[c].push_back({l, d});
    exp_q[c].push_back({l, d});
    if (l) tx_msgs_m++;
  endtask

  // One inbound message: header beat then len body beats; model decides delivery or drop
  task automatic queue_rx(input logic [W-1:0] hdr, input bit hlast, input int len, input logic [W-1:0] d0);
    int id;
    rx_q.push_back({hlast, hdr});
    if (hlast) begin
      drops_m++;
    end else begin
      id = int'(hdr[ID_W-1:0]);
      if (id < N) rx_msgs_m++;
      else        drops_m++;
      for (int b = 0; b < len; b++) begin
        rx_q.push_back({(b == len - 1), d0 + W'(b)});
        if (id < N) dn_exp.push_back({8'(id), (b == len - 1), d0 + W'(b)});
      end
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < N; c++) begin
      tx_q[c].delete();
      exp_q[c].delete();
      pres[c] = 1'b0;
    end
    rx_q.delete();
    dn_exp.delete();
    hdr_log.delete();
    rx_pres = 1'b0; hdr_checked = 1'b0; idle_prev = 1'b0; ena_prev = '0;
    mon_mode = 0; cur_ch = 0; last_m = N - 1; stall_hold = 0; stalls = 0;
    tx_msgs_m = 0; rx_msgs_m = 0; drops_m = 0;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      if (!pres[c] && tx_q[c].size() > 0 && int'($urandom_range(99)) < gap_pct) pres[c] = 1'b1;
      up_ena[c] = pres[c];
      up_v[c*W +: W] = pres[c] ? tx_q[c][0].data : '0;
      up_last[c] = pres[c] ? tx_q[c][0].last : 1'b0;
    end
    send_rdy = int'($urandom_range(99)) < srdy_pct;
    if (!rx_pres && rx_q.size() > 0 && int'($urandom_range(99)) < rx_gap_pct) rx_pres = 1'b1;
    recv_ena  = rx_pres;
    recv_v    = rx_pres ? rx_q[0].data : '0;
    recv_last = rx_pres ? rx_q[0].last : 1'b0;
    for (int c = 0; c < N; c++) down_rdy[c] = (stall_hold > 0) ? 1'b0 : (int'($urandom_range(99)) < drdy_pct);
    if (stall_hold > 0) stall_hold--;
  endtask

  task automatic observe();
    dn_t e;
    beat_t b;
    logic [N-1:0] ev;
    int exp_id;
    bit nidle;
    check_eq("down_onehot", 64'($onehot0(down_ena)), 64'd1);
    if (down_ena != '0) begin
      check_eq("down_expected", 64'(dn_exp.size() > 0), 64'd1);
      check_eq("rx_ready_follow", 64'(recv_rdy), 64'(|(down_ena & down_rdy)));
      if ((down_ena & down_rdy) == '0) begin
        stalls++;
      end else if (dn_exp.size() > 0) begin
        e = dn_exp.pop_front();
        ev = '0;
        ev[e.ch] = 1'b1;
        check_eq("down_ch", 64'(down_ena), 64'(ev));
        check_eq("down_data", 64'(down_v), 64'(e.data));
        check_eq("down_last", 64'(down_last), 64'(e.last));
      end
    end
    if (recv_ena && recv_rdy) begin
      void'(rx_q.pop_front());
      rx_pres = 1'b0;
    end
    for (int c = 0; c < N; c++) begin
      if (up_ena[c] && up_rdy[c]) begin
        void'(tx_q[c].pop_front());
        pres[c] = 1'b0;
      end
    end
    nidle = (mon_mode == 0) && !send_ena;
    if (mon_mode == 0) begin
      check_eq("up_rdy_idle", 64'(up_rdy), 64'd0);
      if (idle_prev && ena_prev != '0) check_eq("hdr_latency", 64'(send_ena), 64'd1);
      if (send_ena) begin
        if (!hdr_checked) begin
          exp_id = rr_pick(ena_prev, last_m);
          check_eq("hdr_id", 64'(send_v), 64'(exp_id));
          check_eq("hdr_last", 64'(send_last), 64'd0);
          hdr_log.push_back(int'(send_v));
          cur_ch = (exp_id < 0) ? 0 : exp_id;
          hdr_checked = 1'b1;
        end
        if (send_rdy) begin
          mon_mode = 1;
          hdr_checked = 1'b0;
        end
      end
    end else begin
      ev = '1;
      ev[cur_ch] = 1'b0;
      check_eq("chan_lock", 64'(up_rdy & ev), 64'd0);
      if (send_ena && send_rdy) begin
        check_eq("body_expected", 64'(exp_q[cur_ch].size() > 0), 64'd1);
        if (exp_q[cur_ch].size() > 0) begin
          b = exp_q[cur_ch].pop_front();
          check_eq("body_beat", 64'({send_last, send_v}), 64'(b));
          if (b.last) begin
            mon_mode = 0;
            last_m = cur_ch;
          end
        end
      end
    end
    idle_prev = nidle;
    ena_prev  = up_ena;
  endtask

  task automatic step();
    @(negedge CLK);
    drive();
    #4;
    observe();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    bit done = all_empty();
    while (!done && k < budget) begin
      step();
      k++;
      done = all_empty();
    end
    check_eq("drain_done", 64'(done), 64'd1);
    step();
  endtask

  task automatic check_stats();
    int etx, erx, edr;
`ifdef VSIM_MUX_STATS_EN
    etx = tx_msgs_m; erx = rx_msgs_m; edr = drops_m;
`else
    etx = 0; erx = 0; edr = 0;
`endif
    check_eq("stat_tx_msgs", 64'(stat_tx), 64'(etx));
    check_eq("stat_rx_msgs", 64'(stat_rx), 64'(erx));
    check_eq("stat_drops", 64'(stat_drops), 64'(edr));
  endtask

  task automatic check_rst_outputs(input string tag);
    check_eq({tag, "_send_ena"}, 64'(send_ena), 64'd0);
    check_eq({tag, "_up_rdy"}, 64'(up_rdy), 64'd0);
    check_eq({tag, "_recv_rdy"}, 64'(recv_rdy), 64'd1);
    check_eq({tag, "_down_ena"}, 64'(down_ena), 64'd0);
    check_eq({tag, "_stats"}, 64'({stat_tx, stat_rx, stat_drops}), 64'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    nRST = 1'b0;
    up_ena = '0; up_v = '0; up_last = '0; send_rdy = 1'b0;
    recv_ena = 1'b0; recv_v = '0; recv_last = 1'b0; down_rdy = '0;
    gap_pct = 100; srdy_pct = 100; rx_gap_pct = 100; drdy_pct = 100;
    clear_model();
    #1;
    check_rst_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // Single outbound message on channel 2: header, then A, B, C
    push_tx(2, 32'hA, 1'b0);
    push_tx(2, 32'hB, 1'b0);
    push_tx(2, 32'hC, 1'b1);
    step();
    check_eq("t1_idle", 64'(send_ena), 64'd0);
    step();
    check_eq("t1_hdr", 64'({send_ena, send_last, send_v}), 64'({1'b1, 1'b0, 32'h2}));
    step();
    check_eq("t1_beat_a", 64'({send_ena, send_last, send_v}), 64'({1'b1, 1'b0, 32'hA}));
    step();
    check_eq("t1_beat_b", 64'({send_ena, send_last, send_v}), 64'({1'b1, 1'b0, 32'hB}));
    step();
    check_eq("t1_beat_c", 64'({send_ena, send_last, send_v}), 64'({1'b1, 1'b1, 32'hC}));
    drain(20);
    check_stats();

    // Inbound steering to channel 1 with a two-cycle downstream stall
    stalls = 0;
    stall_hold = 3;
    queue_rx(32'h1, 1'b0, 2, 32'h1234_0000);
    drain(20);
    check_eq("steer_stalls", 64'(stalls), 64'd2);

    // Out-of-range id 7 with two body beats, then an empty message
    queue_rx(32'h7, 1'b0, 2, $urandom);
    queue_rx(32'h3, 1'b1, 0, 32'h0);
    drain(20);
    check_stats();

    // Round-robin with all channels requesting: ready always high, then random
    for (int pass = 0; pass < 2; pass++) begin
      srdy_pct = (pass == 0) ? 100 : 50;
      rr_base = (last_m + 1) % N;
      hdr_log.delete();
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < N; c++) begin
          push_tx(c, $urandom, 1'b0);
          push_tx(c, $urandom, 1'b1);
        end
      drain(400);
      check_eq("rr_count", 64'(hdr_log.size()), 64'(2 * N));
      for (int i = 0; i < hdr_log.size(); i++) check_eq("rr_order", 64'(hdr_log[i]), 64'((rr_base + i) % N));
    end

    // Full-duplex random traffic on both paths
    gap_pct = 60; srdy_pct = 70; rx_gap_pct = 60; drdy_pct = 60;
    for (int k = 0; k < 40; k++) begin
      int c, len;
      c = int'($urandom_range(N - 1));
      len = 1 + int'($urandom_range(3));
      for (int b = 0; b < len; b++) push_tx(c, $urandom, (b == len - 1));
    end
    for (int k = 0; k < 30; k++) queue_rx($urandom, ($urandom_range(7) == 0), 1 + int'($urandom_range(2)), $urandom);
    drain(3000);
    check_stats();

    // Asynchronous reset in the middle of a channel-3 message
    gap_pct = 100; srdy_pct = 100; rx_gap_pct = 100; drdy_pct = 100;
    for (int b = 0; b < 8; b++) push_tx(3, $urandom, (b == 7));
    for (int k = 0; k < 50 && !(mon_mode == 1 && exp_q[3].size() <= 5); k++) step();
    check_eq("rst_in_body", 64'(mon_mode == 1 && cur_ch == 3), 64'd1);
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check_rst_outputs("mid_reset");
    clear_model();
    up_ena = '0; up_last = '0; recv_ena = 1'b0; recv_last = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = N - 1; c >= 0; c--) push_tx(c, $urandom, 1'b1);
    step();
    check_eq("post_rst_idle", 64'(send_ena), 64'd0);
    step();
    check_eq("post_rst_hdr", 64'({send_ena, send_v}), 64'({1'b1, 32'h0}));
    drain(200);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
